// File: rtl/score_fetch.sv
// ---------------------------------------------------------------------------
// score_fetch
//
// Multi-channel sequence fetcher in front of one external synchronous ROM.
// Each channel walks the ROM from its own start address and holds one word
// at a time for its consumer. A channel stops after it delivers a word whose
// top nibble equals END_NIB. A round-robin arbiter shares the single ROM
// port, and each channel keeps at most one fetch in flight.
//
// Fetch timeline for a grant in cycle T:
//   T   : grant decided, rom_addr/tag registered at the end of T
//   T+1 : ROM samples rom_addr
//   T+2 : rom_data valid, written into the tagged buffer at the end of T+2
//   T+3 : word_valid high
//
// Parameters
//   CH      number of channels (1..8)
//   AW      ROM address width
//   DW      ROM word width (>= 8)
//   END_NIB top-nibble value that marks the last word of a sequence
//
// Ports
//   clk         rising-edge clock
//   asyncrst    asynchronous active-high reset
//   start       per-channel start/restart pulse
//   start_addr  per-channel first word address (CH*AW), sampled on start
//   rom_addr    registered ROM address
//   rom_data    ROM read data, one cycle after rom_addr
//   word_valid  per-channel buffer full
//   word_data   per-channel buffered word (CH*DW)
//   word_ready  per-channel consumer accept
//   busy        per-channel active flag
//   done        per-channel pulse after the end word is accepted
//
// Configuration macro
//   SCORE_FETCH_LOOP_EN  when defined, acceptance of the end word restarts
//                        the channel at the address of its last start and
//                        the channel stays busy (done still pulses).
// ---------------------------------------------------------------------------
module score_fetch #(
    parameter int         CH      = 4,
    parameter int         AW      = 13,
    parameter int         DW      = 16,
    parameter logic [3:0] END_NIB = 4'hF
) (
    input  logic             clk,
    input  logic             asyncrst,
    input  logic [CH-1:0]    start,
    input  logic [CH*AW-1:0] start_addr,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic [CH-1:0]    word_valid,
    output logic [CH*DW-1:0] word_data,
    input  logic [CH-1:0]    word_ready,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);

    localparam int TW = (CH > 1) ? $clog2(CH) : 1;

    // Per-channel state
    logic [AW-1:0] ptr_q [CH];
    logic [AW-1:0] ptr_d [CH];
    logic [DW-1:0] buf_q [CH];
    logic [DW-1:0] buf_d [CH];
    logic [CH-1:0] valid_q,    valid_d;
    logic [CH-1:0] inflight_q, inflight_d;
    logic [CH-1:0] drop_q,     drop_d;
    logic [CH-1:0] halt_q,     halt_d;
    logic [CH-1:0] busy_q,     busy_d;
    logic [CH-1:0] done_q,     done_d;

`ifdef SCORE_FETCH_LOOP_EN
    logic [AW-1:0] loop_addr_q [CH];
    logic [AW-1:0] loop_addr_d [CH];
`endif

    // Shared fetch path
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [TW-1:0] arb_q,      arb_d;
    logic          s1_vld_q,   s1_vld_d;
    logic [TW-1:0] s1_tag_q,   s1_tag_d;
    logic          s2_vld_q,   s2_vld_d;
    logic [TW-1:0] s2_tag_q,   s2_tag_d;

    logic [CH-1:0] eligible;
    logic          grant_vld;
    logic [TW-1:0] grant_idx;
    logic [TW-1:0] cand;
    logic          ret_hit;
    logic          acc_hit;
    logic          end_hit;

    // Channel index 'off' places after 'base', wrapping at CH.
    function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= CH) begin
            sum = sum - CH;
        end
        return sum[TW-1:0];
    endfunction

    // A channel being (re)started this cycle is held off for one cycle so the
    // old pointer is never fetched after a restart.
    assign eligible = busy_q & ~valid_q & ~inflight_q & ~halt_q & ~start;

    // Round-robin search starting at arb_q, which points one past the last grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < CH; i++) begin
            cand = rr_idx(arb_q, i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        arb_d      = grant_vld ? rr_idx(grant_idx, 1) : arb_q;
        rom_addr_d = grant_vld ? ptr_q[grant_idx] : rom_addr_q;
        s1_vld_d   = grant_vld;
        s1_tag_d   = grant_idx;
        s2_vld_d   = s1_vld_q;
        s2_tag_d   = s1_tag_q;
    end

    // Per-channel next state. Priority, lowest first: grant, ROM return,
    // consumer acceptance, start (restart overrides everything else).
    always_comb begin
        ptr_d      = ptr_q;
        buf_d      = buf_q;
        valid_d    = valid_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        halt_d     = halt_q;
        busy_d     = busy_q;
        done_d     = '0;
`ifdef SCORE_FETCH_LOOP_EN
        loop_addr_d = loop_addr_q;
`endif
        ret_hit = 1'b0;
        acc_hit = 1'b0;
        end_hit = 1'b0;
        for (int c = 0; c < CH; c++) begin
            ret_hit = s2_vld_q && (s2_tag_q == TW'(c));
            acc_hit = valid_q[c] && word_ready[c];
            end_hit = (buf_q[c][DW-1 -: 4] == END_NIB);

            if (grant_vld && (grant_idx == TW'(c))) begin
                ptr_d[c]      = ptr_q[c] + AW'(1);
                inflight_d[c] = 1'b1;
            end

            // A return flagged for dropping belongs to a sequence that was
            // restarted while the fetch was in flight.
            if (ret_hit) begin
                inflight_d[c] = 1'b0;
                if (drop_q[c]) begin
                    drop_d[c] = 1'b0;
                end else begin
                    buf_d[c]   = rom_data;
                    valid_d[c] = 1'b1;
                    halt_d[c]  = (rom_data[DW-1 -: 4] == END_NIB);
                end
            end

            if (acc_hit) begin
                valid_d[c] = 1'b0;
                halt_d[c]  = 1'b0;
                if (end_hit) begin
`ifdef SCORE_FETCH_LOOP_EN
                    ptr_d[c] = loop_addr_q[c];
`else
                    busy_d[c] = 1'b0;
`endif
                    done_d[c] = 1'b1;
                end
            end

            // A fetch still in flight at restart (and not returning right now)
            // must be discarded when it arrives.
            if (start[c]) begin
                ptr_d[c]   = start_addr[c*AW +: AW];
                busy_d[c]  = 1'b1;
                valid_d[c] = 1'b0;
                halt_d[c]  = 1'b0;
                done_d[c]  = 1'b0;
                drop_d[c]  = inflight_d[c];
`ifdef SCORE_FETCH_LOOP_EN
                loop_addr_d[c] = start_addr[c*AW +: AW];
`endif
            end
        end
    end

    // All state registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
            ptr_q      <= '{default: '0};
            buf_q      <= '{default: '0};
            valid_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            halt_q     <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            rom_addr_q <= '0;
            arb_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_tag_q   <= '0;
`ifdef SCORE_FETCH_LOOP_EN
            loop_addr_q <= '{default: '0};
`endif
        end else begin
            ptr_q      <= ptr_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
            arb_q      <= arb_d;
            s1_vld_q   <= s1_vld_d;
            s1_tag_q   <= s1_tag_d;
            s2_vld_q   <= s2_vld_d;
            s2_tag_q   <= s2_tag_d;
`ifdef SCORE_FETCH_LOOP_EN
            loop_addr_q <= loop_addr_d;
`endif
        end
    end

    always_comb begin
        word_data = '0;
        for (int c = 0; c < CH; c++) begin
            word_data[c*DW +: DW] = buf_q[c];
        end
    end

    assign rom_addr   = rom_addr_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/score_fetch.md
SCORE_FETCH -- requirements
Module: score_fetch

Interface
REQ-001 Parameter CH, default 4: number of independent sequence channels (1..8).
REQ-002 Parameter AW, default 13: ROM address width.
REQ-003 Parameter DW, default 16: ROM word width (>= 8).
REQ-004 Parameter END_NIB, default 4'hF: top-nibble value marking an end-of-sequence word.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 asyncrst  in  1  asynchronous, active-high reset.
REQ-007 start  in  CH  per-channel one-cycle start/restart pulse.
REQ-008 start_addr  in  CH*AW  per-channel first word address, sampled on start.
REQ-009 rom_addr  out  AW  registered address to external synchronous ROM.
REQ-010 rom_data  in  DW  ROM output, valid one cycle after rom_addr changes.
REQ-011 word_valid  out  CH  channel word buffer holds a word.
REQ-012 word_data  out  CH*DW  per-channel buffered word.
REQ-013 word_ready  in  CH  consumer accepts word when valid & ready.
REQ-014 busy  out  CH  channel active (started, not halted).
REQ-015 done  out  CH  one-cycle pulse when end word is accepted.

Function
REQ-016 Each channel SHALL hold pointer (AW), one-word buffer, in-flight flag, drop flag, busy flag.
REQ-017 Channel eligible for fetch SHALL be: busy & ~word_valid & ~in-flight & ~halt-pending.
REQ-018 Round-robin arbiter SHALL grant at most one eligible channel per cycle, searching from channel after last grant.
REQ-019 On grant in cycle T: rom_addr <= pointer, tag <= channel, pointer <= pointer+1 (mod 2^AW), in-flight set.
REQ-020 Returned rom_data SHALL be written to tagged channel buffer at end of T+2; word_valid high from T+3; in-flight cleared same edge.
REQ-021 Buffer SHALL clear on valid & ready; next fetch for that channel eligible the following cycle (sustained rate per channel one word per 4 cycles; aggregate up to one per cycle).
REQ-022 Word with top nibble == END_NIB SHALL be delivered like any word, then channel issues no further fetch; busy drops and done pulses in the cycle after end word is accepted.
REQ-023 start on idle channel: pointer <= start_addr, busy set, next cycle eligible.
REQ-024 start on busy channel: buffer flushed (word_valid 0 next cycle), pointer reloaded, done not pulsed; if in-flight, drop flag set and that return SHALL be discarded, channel eligible after discard.
REQ-025 start coincident with word acceptance: restart wins; accepted word consumed, no done pulse even if end word.
REQ-026 Pointer SHALL wrap 2^AW-1 -> 0 without error.
REQ-027 word_data of channels with word_valid 0 SHALL hold last value (don't-care to consumer).

Reset
REQ-028 While asyncrst high: rom_addr 0, word_valid 0, word_data 0, busy 0, done 0, all pointers/flags 0, arbiter pointer at channel 0.
REQ-029 Reset asserted mid-fetch SHALL abandon in-flight words; first grant after release only after a start.

Configuration
REQ-030 Macro SCORE_FETCH_LOOP_EN: when defined, end word acceptance reloads pointer from start_addr captured at last start, busy stays 1, done still pulses, fetching continues.
REQ-031 Without SCORE_FETCH_LOOP_EN: channel halts per REQ-022.

Verification
REQ-032 CH=4; ROM[0x000..0x002]=1032,0002,F000; start[0] start_addr 0x000, ready=1 -> words 1032,0002,F000 on ch0, first valid 4 cycles after start, done[0] after F000, busy[0] 0.
REQ-033 All 4 channels started same cycle, distinct programs of 3 words, ready=1 -> grants 0,1,2,3 rotating, every channel delivers its 3 words in order, no cross-channel corruption.
REQ-034 ch1 ready held 0 for 20 cycles -> ch1 word_valid held, word_data stable, rom_addr never shows ch1 address in that window, others unaffected.
REQ-035 start[2] again 1 cycle after ch2 grant (in-flight) with new start_addr 0x100 -> stale word dropped, first delivered word is ROM[0x100].
REQ-036 start_addr 0x1FFF, ROM[0x1FFF]=0005, ROM[0x0000]=F000 -> words 0005, F000 delivered; pointer wrapped.
REQ-037 With SCORE_FETCH_LOOP_EN, 3-word program -> sequence repeats twice with done pulse after each F000, busy stays 1; without macro -> single pass.
